// File: rtl/write_arb_pkg.sv
// write_arb_pkg: shared defaults, slot state type and lane-id width helper for write_lane_arbiter
package write_arb_pkg;
  localparam int NUM_LANES_DEF = 4;
  localparam int DATA_WIDTH_DEF = 1024;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int CNT_WIDTH_DEF = 16;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;
  function automatic int lane_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: picks the first eligible lane scanning upward from rr_ptr, modulo NUM_LANES
module rr_priority_picker import write_arb_pkg::*; #(
  parameter int NUM_LANES = NUM_LANES_DEF
) (
  input  logic [NUM_LANES-1:0]                eligible,
  input  logic [lane_id_w(NUM_LANES)-1:0]     rr_ptr,
  output logic [NUM_LANES-1:0]                onehot,
  output logic [lane_id_w(NUM_LANES)-1:0]     idx,
  output logic                                any
);
  localparam int LW = lane_id_w(NUM_LANES);
  logic [LW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      j = LW'((int'(rr_ptr) + k) % NUM_LANES);
      idx = eligible[j] ? j : idx;
    end
  end
  assign any = |eligible;
  assign onehot = any ? (NUM_LANES'(1) << idx) : '0;
endmodule

// File: rtl/write_lane_arbiter.sv
// write_lane_arbiter: round-robin arbiter of lane write requests into a single-entry valid/ready slot
// Optional per-lane saturating grant counters via `define WRITE_ARB_STATS_EN
module write_lane_arbiter import write_arb_pkg::*; #(
`ifdef WRITE_ARB_STATS_EN
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
`endif
  parameter int NUM_LANES  = NUM_LANES_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_LANES-1:0]             lane_write_req,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]  lane_dst_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]  lane_data,
  output logic [NUM_LANES-1:0]             lane_write_gnt,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ADDR_WIDTH-1:0]            out_dst_addr,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [lane_id_w(NUM_LANES)-1:0]  out_lane_id
`ifdef WRITE_ARB_STATS_EN
  ,
  output logic [NUM_LANES*CNT_WIDTH-1:0]   grant_count
`endif
);
  localparam int LW = lane_id_w(NUM_LANES);
  slot_state_e state;
  logic [LW-1:0] rr_ptr, win_idx;
  logic [NUM_LANES-1:0] eligible, win_onehot;
  logic win_any, capture;
  // The lane granted last cycle still holds req for one cycle; mask it out.
  assign eligible = lane_write_req & ~lane_write_gnt;
  assign capture = (state == EMPTY || out_ready) && win_any;
  assign out_valid = (state == FULL);
  rr_priority_picker #(.NUM_LANES(NUM_LANES)) u_picker (
    .eligible(eligible),
    .rr_ptr(rr_ptr),
    .onehot(win_onehot),
    .idx(win_idx),
    .any(win_any)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      rr_ptr <= '0;
      lane_write_gnt <= '0;
      out_dst_addr <= '0;
      out_data <= '0;
      out_lane_id <= '0;
    end else begin
      lane_write_gnt <= capture ? win_onehot : '0;
      if (capture) begin
        state <= FULL;
        out_dst_addr <= lane_dst_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        out_data <= lane_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
        out_lane_id <= win_idx;
        rr_ptr <= (win_idx == LW'(NUM_LANES - 1)) ? '0 : win_idx + 1'b1;
      end else if (out_ready) begin
        state <= EMPTY;
      end
    end
  end
`ifdef WRITE_ARB_STATS_EN
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (capture && win_onehot[i] && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign grant_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`endif
endmodule
